cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 113 +++++++++++
 tb/tb_cpu_step_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Single-step / run / burst controller that gates a CPU through a one-cycle clock enable.
// Buttons are edge-detected in-house; all outputs come straight from flops or the state register.
module cpu_step_ctrl #(
    parameter int unsigned RUN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        btn_burst,
    input  logic [7:0]  burst_n,
    output logic        cpu_en,
    output logic        running,
    output logic        busy,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

    state_t      state_reg;
    logic [2:0]  btn_prev_reg;
    logic [15:0] div_cnt_reg;
    logic [7:0]  remaining_reg;
    logic        cpu_en_reg;
    logic [15:0] step_cnt_reg;

    logic [2:0] btn_lvl;
    logic       step_rise;
    logic       run_rise;
    logic       burst_rise;

    assign btn_lvl    = {btn_burst, btn_run, btn_step};
    assign step_rise  = btn_step  & ~btn_prev_reg[0];
    assign run_rise   = btn_run   & ~btn_prev_reg[1];
    assign burst_rise = btn_burst & ~btn_prev_reg[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= PAUSE;
            btn_prev_reg  <= 3'b111;
            div_cnt_reg   <= 16'd0;
            remaining_reg <= 8'd0;
            cpu_en_reg    <= 1'b0;
            step_cnt_reg  <= 16'd0;
        end else begin
            btn_prev_reg <= btn_lvl;
            step_cnt_reg <= step_cnt_reg + 16'(cpu_en_reg);
            cpu_en_reg   <= 1'b0;

            case (state_reg)
                PAUSE: begin
                    if (run_rise) begin
                        state_reg   <= RUN;
                        div_cnt_reg <= 16'd0;
                    end else if (burst_rise) begin
                        // The first pulse is issued on entry, so remaining holds the pulses still owed after it.
                        if (burst_n != 8'd0) begin
                            state_reg     <= BURST;
                            cpu_en_reg    <= 1'b1;
                            remaining_reg <= burst_n - 8'd1;
                        end
                    end else if (step_rise) begin
                        cpu_en_reg <= 1'b1;
                    end
                end

                RUN: begin
                    if (run_rise) begin
                        state_reg     <= PAUSE;
                        div_cnt_reg   <= 16'd0;
                        remaining_reg <= 8'd0;
                    end else if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= 16'd0;
                        cpu_en_reg  <= 1'b1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 16'd1;
                    end
                end

                BURST: begin
                    if (run_rise) begin
                        state_reg     <= PAUSE;
                        div_cnt_reg   <= 16'd0;
                        remaining_reg <= 8'd0;
                    end else if (remaining_reg != 8'd0) begin
                        cpu_en_reg    <= 1'b1;
                        remaining_reg <= remaining_reg - 8'd1;
                    end else begin
                        state_reg <= PAUSE;
                    end
                end

                default: begin
                    state_reg     <= PAUSE;
                    div_cnt_reg   <= 16'd0;
                    remaining_reg <= 8'd0;
                end
            endcase
        end
    end

    assign cpu_en   = cpu_en_reg;
    assign running  = (state_reg == RUN);
    assign busy     = (state_reg != PAUSE);
    assign step_cnt = step_cnt_reg;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: per-cycle expectations queued as stimulus is driven, checked after each edge.
// A second instance with RUN_DIV=1 runs continuously to carry step_cnt through its wrap point.
module tb_cpu_step_ctrl;

    logic        clk;
    logic        rst;
    logic        b_step, b_run, b_burst;
    logic [7:0]  bn;
    logic        cpu_en, running, busy;
    logic [15:0] step_cnt;

    logic        r_step, r_run, r_burst;
    logic [7:0]  r_bn;
    logic        cpu_en1, running1, busy1;
    logic [15:0] step_cnt1;

    int checks;
    int errors;
    logic [15:0] exp_cnt;

    typedef struct {
        logic        en;
        logic        run;
        logic        busy;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    cpu_step_ctrl #(.RUN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (b_step),
        .btn_run   (b_run),
        .btn_burst (b_burst),
        .burst_n   (bn),
        .cpu_en    (cpu_en),
        .running   (running),
        .busy      (busy),
        .step_cnt  (step_cnt)
    );

    cpu_step_ctrl #(.RUN_DIV(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (r_step),
        .btn_run   (r_run),
        .btn_burst (r_burst),
        .burst_n   (r_bn),
        .cpu_en    (cpu_en1),
        .running   (running1),
        .busy      (busy1),
        .step_cnt  (step_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue the outputs expected after the next edge, advance one clock, then compare.
    task automatic cyc(input logic e_en, input logic e_run, input logic e_busy, input string tag);
        exp_t e;
        exp_t got;
        e.en   = e_en;
        e.run  = e_run;
        e.busy = e_busy;
        e.cnt  = exp_cnt;
        e.tag  = tag;
        exp_q.push_back(e);
        if (e_en)
            exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({got.tag, "/cpu_en"},   {15'd0, cpu_en},  {15'd0, got.en});
        chk({got.tag, "/running"},  {15'd0, running}, {15'd0, got.run});
        chk({got.tag, "/busy"},     {15'd0, busy},    {15'd0, got.busy});
        chk({got.tag, "/step_cnt"}, step_cnt,         got.cnt);
        $display("cycle %s en=%0b run=%0b busy=%0b cnt=%0d", got.tag, cpu_en, running, busy, step_cnt);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 16'd0;
        rst     = 1'b1;
        b_step  = 1'b0; b_run = 1'b0; b_burst = 1'b0; bn = 8'd0;
        r_step  = 1'b0; r_run = 1'b0; r_burst = 1'b0; r_bn = 8'd0;

        // Reset state
        #12;
        chk("reset/cpu_en",   {15'd0, cpu_en},  16'd0);
        chk("reset/running",  {15'd0, running}, 16'd0);
        chk("reset/busy",     {15'd0, busy},    16'd0);
        chk("reset/step_cnt", step_cnt,         16'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, "idle");
        cyc(0, 0, 0, "idle");

        // Single step held for 10 cycles
        b_step = 1'b1;
        cyc(1, 0, 0, "step");
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, "step_hold");
        b_step = 1'b0;
        cyc(0, 0, 0, "step_rel");

        // Burst of 5; burst_n changes right after entry and must not matter
        bn = 8'd5;
        b_burst = 1'b1;
        cyc(1, 0, 1, "burst5");
        bn = 8'd9;
        cyc(1, 0, 1, "burst5");
        b_burst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, "burst5");
        cyc(0, 0, 0, "burst5_end");
        cyc(0, 0, 0, "burst5_idle");

        // Burst with burst_n == 0 is ignored
        bn = 8'd0;
        b_burst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, "burst0");
        b_burst = 1'b0;
        cyc(0, 0, 0, "burst0_rel");

        // Run with divide-by-4 for 20 cycles, then pause
        b_run = 1'b1;
        cyc(0, 1, 1, "run_entry");
        b_run = 1'b0;
        for (int k = 1; k <= 20; k++) cyc((k % 4) == 0, 1, 1, "run");
        b_run = 1'b1;
        cyc(0, 0, 0, "run_pause");
        b_run = 1'b0;
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, "paused");

        // Run and step rise together: run wins, step discarded; later step/burst rises ignored
        b_run = 1'b1;
        b_step = 1'b1;
        cyc(0, 1, 1, "run_step_entry");
        b_run = 1'b0;
        b_step = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            b_step  = (k == 2);
            b_burst = (k == 5);
            bn      = 8'd3;
            cyc((k % 4) == 0, 1, 1, "run_ignore");
        end
        b_step = 1'b0;
        b_burst = 1'b0;
        b_run = 1'b1;
        cyc(0, 0, 0, "run2_pause");
        b_run = 1'b0;
        cyc(0, 0, 0, "paused2");

        // Asynchronous reset during burst cycle 2 of 8, step held through release
        bn = 8'd8;
        b_burst = 1'b1;
        cyc(1, 0, 1, "burst8");
        b_burst = 1'b0;
        cyc(1, 0, 1, "burst8");
        #2;
        rst = 1'b1;
        b_step = 1'b1;
        #1;
        chk("async_rst/cpu_en",   {15'd0, cpu_en},  16'd0);
        chk("async_rst/running",  {15'd0, running}, 16'd0);
        chk("async_rst/busy",     {15'd0, busy},    16'd0);
        chk("async_rst/step_cnt", step_cnt,         16'd0);
        exp_cnt = 16'd0;
        cyc(0, 0, 0, "in_reset");
        cyc(0, 0, 0, "in_reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, "held_after_rst");
        b_step = 1'b0;
        cyc(0, 0, 0, "step_release");
        b_step = 1'b1;
        cyc(1, 0, 0, "step_repress");
        b_step = 1'b0;
        cyc(0, 0, 0, "step_repress_end");

        // step_cnt wrap on the RUN_DIV=1 instance: 65535 continuous pulses, then one step
        r_run = 1'b1;
        @(posedge clk); #1;
        r_run = 1'b0;
        @(posedge clk); #1;
        chk("wrap/continuous_en", {15'd0, cpu_en1}, 16'd1);
        repeat (65534) @(posedge clk);
        #1;
        r_run = 1'b1;
        @(posedge clk); #1;
        r_run = 1'b0;
        chk("wrap/paused",       {15'd0, running1}, 16'd0);
        chk("wrap/pre_cnt",      step_cnt1,         16'hFFFF);
        @(posedge clk); #1;
        chk("wrap/no_en_paused", {15'd0, cpu_en1},  16'd0);
        r_step = 1'b1;
        @(posedge clk); #1;
        r_step = 1'b0;
        chk("wrap/step_en",      {15'd0, cpu_en1},  16'd1);
        @(posedge clk); #1;
        chk("wrap/cnt_zero",     step_cnt1,         16'h0000);
        $display("wrap step_cnt=%0h", step_cnt1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
